// File: rtl/pc_stack.sv
// Program counter with a LIFO return-address stack, PC-relative branch and
// configurable increment step. All outputs come from registered state.
module pc_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int STEP  = 1,
    localparam int SPW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] offset,
    input  logic             load,
    input  logic             call,
    input  logic             ret,
    input  logic             branch,
    input  logic             inc,
    output logic [WIDTH-1:0] out,
    output logic [SPW-1:0]   sp_count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [DEPTH-1:0][WIDTH-1:0] stack;
    logic [SPW-1:0]              sp_m1;
    logic [AW-1:0]               wr_idx, rd_idx;

    assign full   = (sp_count == SPW'(DEPTH));
    assign empty  = (sp_count == '0);
    assign sp_m1  = sp_count - SPW'(1);
    // Indices are only used when the guard (not full / not empty) holds,
    // so truncation to the array index width is safe.
    assign wr_idx = AW'(sp_count);
    assign rd_idx = AW'(sp_m1);

    // Stack entries are intentionally not reset; stale data is never readable.
    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= '0;
            sp_count  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (load) begin
            out <= in;
        end else if (call) begin
            if (!full) begin
                stack[wr_idx] <= out + STEP_W;
                sp_count      <= sp_count + SPW'(1);
                out           <= in;
            end else begin
                overflow <= 1'b1;
            end
        end else if (ret) begin
            if (!empty) begin
                out      <= stack[rd_idx];
                sp_count <= sp_m1;
            end else begin
                underflow <= 1'b1;
            end
        end else if (branch) begin
            out <= out + offset;
        end else if (inc) begin
            out <= out + STEP_W;
        end
    end
endmodule

// File: tb/tb_pc_stack.sv
// Directed self-checking bench for pc_stack: default configuration plus a
// WIDTH=8 / DEPTH=1 / STEP=2 instance for the parameter sweep.
module tb_pc_stack;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance
    logic        rst, ld, cl, rt, br, ic;
    logic [15:0] din, off, pc;
    logic [3:0]  sp;
    logic        fl, em, ov, un;

    pc_stack dut (
        .clk(clk), .reset(rst), .in(din), .offset(off),
        .load(ld), .call(cl), .ret(rt), .branch(br), .inc(ic),
        .out(pc), .sp_count(sp), .full(fl), .empty(em),
        .overflow(ov), .underflow(un)
    );

    // Sweep instance
    logic       rst2, ld2, cl2, rt2, br2, ic2;
    logic [7:0] din2, off2, pc2;
    logic [0:0] sp2;
    logic       fl2, em2, ov2, un2;

    pc_stack #(.WIDTH(8), .DEPTH(1), .STEP(2)) dut2 (
        .clk(clk), .reset(rst2), .in(din2), .offset(off2),
        .load(ld2), .call(cl2), .ret(rt2), .branch(br2), .inc(ic2),
        .out(pc2), .sp_count(sp2), .full(fl2), .empty(em2),
        .overflow(ov2), .underflow(un2)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        {rst, ld, cl, rt, br, ic} = '0;
        {rst2, ld2, cl2, rt2, br2, ic2} = '0;
        din = '0; off = '0; din2 = '0; off2 = '0;
    endtask

    // One cycle on the default instance; outputs sampled 1 time unit after the edge
    task automatic go(input logic r, input logic l, input logic c, input logic t,
                      input logic b, input logic i, input logic [15:0] a, input logic [15:0] o);
        rst = r; ld = l; cl = c; rt = t; br = b; ic = i; din = a; off = o;
        @(posedge clk); #1;
        idle_all();
    endtask

    task automatic go2(input logic r, input logic l, input logic c, input logic t,
                       input logic i, input logic [7:0] a);
        rst2 = r; ld2 = l; cl2 = c; rt2 = t; ic2 = i; din2 = a;
        @(posedge clk); #1;
        idle_all();
    endtask

    logic [15:0] exp_ret;

    initial begin
        idle_all();
        @(negedge clk);

        // Reset state
        go(1, 0, 0, 0, 0, 0, 0, 0);
        check("rst_out", pc, 0);
        check("rst_sp", sp, 0);
        check("rst_empty", em, 1);
        check("rst_full", fl, 0);
        check("rst_ovf", ov, 0);
        check("rst_udf", un, 0);

        // Increment
        go(0, 0, 0, 0, 0, 1, 0, 0); check("inc1", pc, 16'h0001);
        go(0, 0, 0, 0, 0, 1, 0, 0); check("inc2", pc, 16'h0002);
        go(0, 0, 0, 0, 0, 1, 0, 0); check("inc3", pc, 16'h0003);
        check("inc_empty", em, 1);
        go(0, 0, 0, 0, 0, 0, 0, 0); check("hold", pc, 16'h0003);

        // Wrap-around
        go(0, 1, 0, 0, 0, 0, 16'hFFFE, 0); check("wrap_ld", pc, 16'hFFFE);
        go(0, 0, 0, 0, 0, 1, 0, 0); check("wrap1", pc, 16'hFFFF);
        go(0, 0, 0, 0, 0, 1, 0, 0); check("wrap2", pc, 16'h0000);
        go(0, 0, 0, 0, 0, 1, 0, 0); check("wrap3", pc, 16'h0001);
        go(0, 1, 0, 0, 0, 0, 16'h0010, 0);
        go(0, 0, 0, 0, 1, 0, 0, 16'hFFF0); check("br_neg", pc, 16'h0000);

        // Nested call/return
        go(0, 1, 0, 0, 0, 0, 16'h0100, 0);
        go(0, 0, 1, 0, 0, 0, 16'h0200, 0); check("call1_out", pc, 16'h0200);
        go(0, 0, 1, 0, 0, 0, 16'h0300, 0); check("call2_out", pc, 16'h0300);
        check("call2_sp", sp, 2);
        go(0, 0, 0, 1, 0, 0, 0, 0); check("ret1_out", pc, 16'h0201);
        check("ret1_sp", sp, 1);
        go(0, 0, 0, 1, 0, 0, 0, 0); check("ret2_out", pc, 16'h0101);
        check("ret2_sp", sp, 0);
        check("ret2_empty", em, 1);

        // Fill the stack: call k jumps to 0x1000+16k, pushing previous PC + 1
        go(0, 1, 0, 0, 0, 0, 16'h0000, 0);
        for (int k = 0; k < 8; k++) go(0, 0, 1, 0, 0, 0, 16'h1000 + 16'(k * 16), 0);
        check("fill_out", pc, 16'h1070);
        check("fill_sp", sp, 8);
        check("fill_full", fl, 1);
        check("fill_ovf", ov, 0);
        go(0, 0, 1, 0, 0, 0, 16'h0ABC, 0);
        check("ovf_flag", ov, 1);
        check("ovf_out", pc, 16'h1070);
        check("ovf_sp", sp, 8);
        for (int k = 0; k < 8; k++) begin
            go(0, 0, 0, 1, 0, 0, 0, 0);
            exp_ret = (k == 7) ? 16'h0001 : 16'h1001 + 16'((6 - k) * 16);
            check("drain_out", pc, exp_ret);
        end
        check("drain_empty", em, 1);
        check("drain_udf", un, 0);
        go(0, 0, 0, 1, 0, 0, 0, 0);
        check("udf_flag", un, 1);
        check("udf_out", pc, 16'h0001);
        check("udf_ovf_sticky", ov, 1);
        go(0, 0, 0, 0, 0, 1, 0, 0);
        check("sticky_inc", pc, 16'h0002);
        check("sticky_ovf", ov, 1);
        check("sticky_udf", un, 1);
        go(1, 0, 0, 0, 0, 0, 0, 0);
        check("clr_ovf", ov, 0);
        check("clr_udf", un, 0);

        // Priority
        go(0, 1, 1, 0, 0, 1, 16'h0040, 0);
        check("pri_ld_out", pc, 16'h0040);
        check("pri_ld_sp", sp, 0);
        go(0, 0, 1, 1, 0, 0, 16'h0080, 0);
        check("pri_callret_out", pc, 16'h0080);
        check("pri_callret_sp", sp, 1);
        go(0, 0, 0, 1, 0, 0, 0, 0);
        check("ret_after_call", pc, 16'h0041);
        go(0, 1, 0, 0, 0, 0, 16'h0010, 0);
        go(0, 0, 0, 0, 1, 1, 0, 16'h0005);
        check("pri_br_inc", pc, 16'h0015);
        go(0, 0, 1, 0, 0, 0, 16'h0200, 0);
        check("pre_rst_sp", sp, 1);
        go(1, 1, 1, 1, 1, 1, 16'h1234, 16'h0007);
        check("rst_all_out", pc, 0);
        check("rst_all_sp", sp, 0);
        check("rst_all_empty", em, 1);
        go(0, 0, 0, 1, 0, 0, 0, 0);
        check("rst_discard_udf", un, 1);
        check("rst_discard_out", pc, 0);

        // Parameter sweep: WIDTH=8, DEPTH=1, STEP=2
        go2(1, 0, 0, 0, 0, 0);
        check("sw_rst_empty", em2, 1);
        go2(0, 1, 0, 0, 0, 8'hFE);
        go2(0, 0, 0, 0, 1, 0);
        check("sw_inc_wrap", pc2, 8'h00);
        go2(0, 1, 0, 0, 0, 8'h20);
        go2(0, 0, 1, 0, 0, 8'h10);
        check("sw_call_out", pc2, 8'h10);
        check("sw_full", fl2, 1);
        check("sw_sp", sp2, 1);
        go2(0, 0, 1, 0, 0, 8'h30);
        check("sw_ovf", ov2, 1);
        check("sw_ovf_out", pc2, 8'h10);
        go2(0, 0, 0, 1, 0, 0);
        check("sw_ret", pc2, 8'h22);
        check("sw_empty", em2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
